// File: rtl/fp8_stream_accumulator.sv
// FP8 (1/3/4, bias 3, exp 7 = Inf/NaN) stream accumulator: folds each packet of
// operands into one sum and presents it with a beat count and an overflow flag.

module adder_fp8 #(
    parameter int IMPL_TYPE = 0
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);
    // 0: round to nearest even; anything else: round toward zero.
    localparam bit ROUND_NEAREST = (IMPL_TYPE == 0);

    // Exact magnitude in units of 2^-6 (the smallest subnormal step).
    function automatic logic [9:0] magnitude(input logic [7:0] x);
        logic [4:0] sig;
        int         e_eff;
        sig   = {x[6:4] != 3'd0, x[3:0]};
        e_eff = (x[6:4] == 3'd0) ? 1 : int'(x[6:4]);
        return 10'(sig) << (e_eff - 1);
    endfunction

    logic        a_nan, b_nan, a_inf, b_inf;
    logic [10:0] mag_a, mag_b, mag;
    logic        sgn, guard, sticky;
    logic [5:0]  sig;
    int          lead, shift, exp_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch.
        sum    = 8'h00;
        a_nan  = (a[6:4] == 3'd7) && (a[3:0] != 4'd0);
        b_nan  = (b[6:4] == 3'd7) && (b[3:0] != 4'd0);
        a_inf  = (a[6:4] == 3'd7) && (a[3:0] == 4'd0);
        b_inf  = (b[6:4] == 3'd7) && (b[3:0] == 4'd0);
        mag_a  = {1'b0, magnitude(a)};
        mag_b  = {1'b0, magnitude(b)};
        mag    = 11'd0;
        sgn    = 1'b0;
        guard  = 1'b0;
        sticky = 1'b0;
        sig    = 6'd0;
        lead   = 0;
        shift  = 0;
        exp_i  = 0;

        if (a_nan || b_nan || (a_inf && b_inf && (a[7] != b[7]))) begin
            sum = 8'h78;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else begin
            if (a[7] == b[7]) begin
                mag = mag_a + mag_b;
                sgn = a[7];
            end else if (mag_a >= mag_b) begin
                mag = mag_a - mag_b;
                sgn = (mag == 11'd0) ? 1'b0 : a[7];
            end else begin
                mag = mag_b - mag_a;
                sgn = b[7];
            end

            for (int i = 0; i < 11; i++) begin
                if (mag[i]) lead = i;
            end

            // Below 32 units the value is subnormal or exp=1 and encodes exactly.
            if (lead < 5) begin
                sum = {sgn, mag[6:0]};
            end else begin
                shift  = lead - 4;
                exp_i  = lead - 3;
                sig    = 6'(mag >> shift);
                guard  = mag[shift-1];
                sticky = (mag & ((11'd1 << (shift - 1)) - 11'd1)) != 11'd0;
                if (ROUND_NEAREST && guard && (sticky || sig[0])) sig = sig + 6'd1;
                if (sig[5]) begin
                    sig   = sig >> 1;
                    exp_i = exp_i + 1;
                end
                if (exp_i >= 7) sum = {sgn, 7'h70};
                else            sum = {sgn, 3'(exp_i), 4'(sig)};
            end
        end
    end
endmodule

module fp8_stream_accumulator #(
    parameter int IMPL_TYPE   = 0,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             sum_w;
    logic                   in_accept, out_accept, add_ovf;

    adder_fp8 #(.IMPL_TYPE(IMPL_TYPE)) u_adder (
        .a   (acc_q),
        .b   (in_data),
        .sum (sum_w)
    );

    assign in_accept  = in_valid & in_ready;
    assign out_accept = out_valid & out_ready;
    // Only a finite+finite add that lands on Inf counts as overflow.
    assign add_ovf = (sum_w[6:4] == 3'd7) && (sum_w[3:0] == 4'd0)
                   && (acc_q[6:4] != 3'd7) && (in_data[6:4] != 3'd7);

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so all update together.
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_accept) begin
                acc_d   = in_data;
                count_d = COUNT_WIDTH'(1);
                state_d = in_last ? HOLD : ACCUM;
            end
            ACCUM: if (in_accept) begin
                acc_d   = sum_w;
                count_d = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);
                ovf_d   = ovf_q | add_ovf;
                state_d = in_last ? HOLD : ACCUM;
            end
            HOLD: if (out_accept) begin
                acc_d   = 8'h00;
                count_d = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_data  = acc_q;
        out_count = count_q;
        out_ovf   = ovf_q;
    end
endmodule

// File: tb/tb_fp8_stream_accumulator.sv
// Directed bench for fp8_stream_accumulator: default instance plus a 2-bit
// counter instance for saturation.

module tb_fp8_stream_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, out_ovf;
    logic [7:0] out_data, out_count;

    logic       in2_valid, in2_last, out2_ready;
    logic [7:0] in2_data;
    logic       in2_ready, out2_valid, out2_ovf;
    logic [7:0] out2_data;
    logic [1:0] out2_count;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp8_stream_accumulator #(.IMPL_TYPE(0), .COUNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    fp8_stream_accumulator #(.IMPL_TYPE(0), .COUNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data), .in_last(in2_last),
        .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data),
        .out_count(out2_count), .out_ovf(out2_ovf)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Result must already be valid one cycle after the last accept.
    task automatic take(input string tag, input logic [7:0] d, input logic [7:0] cnt,
                        input logic ovf);
        check({tag, "_valid"}, 16'(out_valid), 16'd1);
        check({tag, "_inrdy"}, 16'(in_ready), 16'd0);
        check({tag, "_data"},  16'(out_data), 16'(d));
        check({tag, "_count"}, 16'(out_count), 16'(cnt));
        check({tag, "_ovf"},   16'(out_ovf), 16'(ovf));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_rdy"}, 16'(in_ready), 16'd1);
        check({tag, "_idle_vld"}, 16'(out_valid), 16'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;
        in2_valid  = 1'b0;
        in2_last   = 1'b0;
        in2_data   = 8'h00;
        out2_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  16'(in_ready), 16'd1);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data",  16'(out_data), 16'h00);
        check("rst_out_count", 16'(out_count), 16'd0);
        check("rst_out_ovf",   16'(out_ovf), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1.0 + 1.0 + 1.0 = 3.0
        send(8'h30, 1'b0);
        send(8'h30, 1'b0);
        check("t1_no_early_valid", 16'(out_valid), 16'd0);
        send(8'h30, 1'b1);
        take("t1", 8'h48, 8'd3, 1'b0);

        // 15.5 + 15.5 overflows to +Inf; flag clears for the next packet
        send(8'h6F, 1'b0);
        send(8'h6F, 1'b1);
        take("t2_ovf", 8'h70, 8'd2, 1'b1);
        send(8'h30, 1'b1);
        take("t2_clear", 8'h30, 8'd1, 1'b0);

        // +Inf + -Inf = NaN, not an overflow; NaN propagates
        send(8'h70, 1'b0);
        send(8'hF0, 1'b1);
        take("t3_inf", 8'h78, 8'd2, 1'b0);
        send(8'h78, 1'b0);
        send(8'h30, 1'b1);
        take("t3_nan", 8'h78, 8'd2, 1'b0);

        // Single -0 beat, held under backpressure
        send(8'h80, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 16'(out_valid), 16'd1);
            check("t4_hold_data",  16'(out_data), 16'h80);
            check("t4_hold_count", 16'(out_count), 16'd1);
            check("t4_hold_inrdy", 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        take("t4", 8'h80, 8'd1, 1'b0);

        // 1.0 + 2.0 with idle gaps = 3.0
        repeat ($urandom_range(1, 4)) @(negedge clk);
        send(8'h30, 1'b0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check("t5_gap_valid", 16'(out_valid), 16'd0);
        check("t5_gap_inrdy", 16'(in_ready), 16'd1);
        send(8'h40, 1'b1);
        take("t5_gaps", 8'h48, 8'd2, 1'b0);

        // Reset in the middle of a packet discards it
        send(8'h30, 1'b0);
        check("t5_accum_data", 16'(out_data), 16'h30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_valid", 16'(out_valid), 16'd0);
        check("t5_rst_acc",   16'(out_data), 16'h00);
        check("t5_rst_count", 16'(out_count), 16'd0);
        check("t5_rst_inrdy", 16'(in_ready), 16'd1);
        send(8'h30, 1'b1);
        take("t5_fresh", 8'h30, 8'd1, 1'b0);

        // Two-bit counter saturates at 3 over five zero beats
        for (int i = 0; i < 5; i++) begin
            in2_valid = 1'b1;
            in2_data  = 8'h00;
            in2_last  = (i == 4);
            check("t6_in2_ready", 16'(in2_ready), 16'd1);
            @(negedge clk);
        end
        in2_valid = 1'b0;
        in2_last  = 1'b0;
        check("t6_valid", 16'(out2_valid), 16'd1);
        check("t6_data",  16'(out2_data), 16'h00);
        check("t6_count", 16'(out2_count), 16'd3);
        check("t6_ovf",   16'(out2_ovf), 16'd0);
        out2_ready = 1'b1;
        @(negedge clk);
        out2_ready = 1'b0;
        check("t6_idle", 16'(out2_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
